rtc_scan_reader: RTL and testbench

RTC_SCAN_READER -- requirements
Module: rtc_scan_reader

---
 rtl/rtc_scan_reader.sv | 212 +++++++++++++++++++++
 tb/tb_rtc_scan_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_scan_reader.sv
// rtl/rtc_scan_reader.sv - periodic RTC bus scanner committing nine BCD time registers atomically
// Optional feature macro: RTC_BCD_CHECK_EN (BCD nibble check, adds err_o)
module rtc_scan_reader #(
  parameter int PHASE_CYCLES   = 5,
  parameter int REFRESH_CYCLES = 2500000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       refresh_i,
  input  logic [7:0] ad_i,
  output logic [7:0] ad_o,
  output logic       ad_oe_o,
  output logic       cs_n_o,
  output logic       rd_n_o,
  output logic       wr_n_o,
  output logic       a_d_o,
  output logic [7:0] R_Segundos,
  output logic [7:0] R_Minutos,
  output logic [7:0] R_Hora,
  output logic [7:0] R_Dia,
  output logic [7:0] R_Mes,
  output logic [7:0] R_Ano,
  output logic [7:0] R_Crono_Seg,
  output logic [7:0] R_Crono_Min,
  output logic [7:0] R_Crono_Hora,
  output logic       valid_o,
  output logic       done_o,
  output logic       busy_o
`ifdef RTC_BCD_CHECK_EN
  ,output logic      err_o
`endif
);

  localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam logic [PW-1:0] PH_LAST = PW'(PHASE_CYCLES - 1);
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_A_SET  = 3'd1;
  localparam logic [2:0] S_A_WR   = 3'd2;
  localparam logic [2:0] S_A_HOLD = 3'd3;
  localparam logic [2:0] S_D_RD   = 3'd4;
  localparam logic [2:0] S_D_END  = 3'd5;
  localparam logic [2:0] S_COMMIT = 3'd6;

  logic [2:0]    r_state;
  logic [PW-1:0] r_phase;
  logic [RW-1:0] r_refresh_cnt;
  logic [3:0]    r_idx;
  logic [7:0]    r_shadow [0:8];
  logic [7:0]    r_out    [0:8];
  logic          r_valid;
  logic          r_done;
  logic          w_refresh_tc;
  logic          w_start;
  logic          w_phase_end;
  logic [7:0]    w_addr;
`ifdef RTC_BCD_CHECK_EN
  logic          r_bad;
  logic          r_err;
  logic          w_bcd_ok;
  assign w_bcd_ok = (ad_i[7:4] <= 4'd9) && (ad_i[3:0] <= 4'd9);
  assign err_o    = r_err;
`endif

  // RTC register address for the current scan index
  always_comb begin
    w_addr = 8'h00;
    case (r_idx)
      4'd0: w_addr = 8'h21;
      4'd1: w_addr = 8'h22;
      4'd2: w_addr = 8'h23;
      4'd3: w_addr = 8'h24;
      4'd4: w_addr = 8'h25;
      4'd5: w_addr = 8'h26;
      4'd6: w_addr = 8'h41;
      4'd7: w_addr = 8'h42;
      4'd8: w_addr = 8'h43;
      default: w_addr = 8'h00;
    endcase
  end

  assign w_refresh_tc = (r_refresh_cnt == RF_LAST);
  assign w_start      = (r_state == S_IDLE) && (refresh_i || w_refresh_tc);
  assign w_phase_end  = (r_phase == PH_LAST);

  // Free-running refresh counter; its terminal count is ignored unless the FSM is idle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_refresh_cnt <= '0;
    end else if (w_refresh_tc) begin
      r_refresh_cnt <= '0;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  // Scan FSM: five timed phases per register, shadows copied to outputs only on commit
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        r_shadow[k] <= 8'h00;
        r_out[k]    <= 8'h00;
      end
`ifdef RTC_BCD_CHECK_EN
      r_bad <= 1'b0;
      r_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef RTC_BCD_CHECK_EN
      r_err <= 1'b0;
`endif
      if (r_state == S_IDLE) begin
        r_phase <= '0;
        if (w_start) begin
          r_state <= S_A_SET;
          r_idx   <= '0;
`ifdef RTC_BCD_CHECK_EN
          r_bad   <= 1'b0;
`endif
        end
      end else if (r_state == S_COMMIT) begin
        r_state <= S_IDLE;
      end else if (!w_phase_end) begin
        r_phase <= r_phase + 1'b1;
      end else begin
        r_phase <= '0;
        case (r_state)
          S_A_SET:  r_state <= S_A_WR;
          S_A_WR:   r_state <= S_A_HOLD;
          S_A_HOLD: r_state <= S_D_RD;
          S_D_RD: begin
            r_shadow[r_idx] <= ad_i;
`ifdef RTC_BCD_CHECK_EN
            if (!w_bcd_ok) r_bad <= 1'b1;
`endif
            r_state <= S_D_END;
          end
          S_D_END: begin
            if (r_idx == 4'd8) begin
              // Output registers load on the edge into COMMIT so they appear together with done_o
              r_state <= S_COMMIT;
`ifdef RTC_BCD_CHECK_EN
              if (r_bad) begin
                r_err <= 1'b1;
              end else begin
                for (int k = 0; k < 9; k++) r_out[k] <= r_shadow[k];
                r_done  <= 1'b1;
                r_valid <= 1'b1;
              end
`else
              for (int k = 0; k < 9; k++) r_out[k] <= r_shadow[k];
              r_done  <= 1'b1;
              r_valid <= 1'b1;
`endif
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= S_A_SET;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Bus levels decoded from the state; address is only driven while the data pins are ours
  always_comb begin
    cs_n_o  = 1'b1;
    rd_n_o  = 1'b1;
    wr_n_o  = 1'b1;
    a_d_o   = 1'b0;
    ad_oe_o = 1'b0;
    ad_o    = 8'h00;
    case (r_state)
      S_A_SET, S_A_WR, S_A_HOLD: begin
        cs_n_o  = 1'b0;
        ad_oe_o = 1'b1;
        ad_o    = w_addr;
        wr_n_o  = (r_state != S_A_WR);
      end
      S_D_RD: begin
        cs_n_o = 1'b0;
        a_d_o  = 1'b1;
        rd_n_o = 1'b0;
      end
      S_D_END: a_d_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = r_done;
  assign valid_o      = r_valid;
  assign R_Segundos   = r_out[0];
  assign R_Minutos    = r_out[1];
  assign R_Hora       = r_out[2];
  assign R_Dia        = r_out[3];
  assign R_Mes        = r_out[4];
  assign R_Ano        = r_out[5];
  assign R_Crono_Seg  = r_out[6];
  assign R_Crono_Min  = r_out[7];
  assign R_Crono_Hora = r_out[8];

endmodule

// File: tb/tb_rtc_scan_reader.sv
// tb/tb_rtc_scan_reader.sv - directed self-checking bench for rtc_scan_reader
module tb_rtc_scan_reader;

  localparam int P = 2;
  localparam int R = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i = 1'b1;
  logic       refresh_i = 1'b0;
  logic [7:0] ad_i;
  logic [7:0] ad_o;
  logic       ad_oe_o, cs_n_o, rd_n_o, wr_n_o, a_d_o;
  logic [7:0] R_Segundos, R_Minutos, R_Hora, R_Dia, R_Mes, R_Ano;
  logic [7:0] R_Crono_Seg, R_Crono_Min, R_Crono_Hora;
  logic       valid_o, done_o, busy_o;
`ifdef RTC_BCD_CHECK_EN
  logic       err_o;
`endif

  rtc_scan_reader #(.PHASE_CYCLES(P), .REFRESH_CYCLES(R)) dut (
    .clk_i(clk), .reset_i(reset_i), .refresh_i(refresh_i),
    .ad_i(ad_i), .ad_o(ad_o), .ad_oe_o(ad_oe_o),
    .cs_n_o(cs_n_o), .rd_n_o(rd_n_o), .wr_n_o(wr_n_o), .a_d_o(a_d_o),
    .R_Segundos(R_Segundos), .R_Minutos(R_Minutos), .R_Hora(R_Hora),
    .R_Dia(R_Dia), .R_Mes(R_Mes), .R_Ano(R_Ano),
    .R_Crono_Seg(R_Crono_Seg), .R_Crono_Min(R_Crono_Min), .R_Crono_Hora(R_Crono_Hora),
    .valid_o(valid_o), .done_o(done_o), .busy_o(busy_o)
`ifdef RTC_BCD_CHECK_EN
    , .err_o(err_o)
`endif
  );

  wire [71:0] w_outs = {R_Segundos, R_Minutos, R_Hora, R_Dia, R_Mes, R_Ano,
                        R_Crono_Seg, R_Crono_Min, R_Crono_Hora};
  wire [12:0] w_bus  = {cs_n_o, rd_n_o, wr_n_o, a_d_o, ad_oe_o, ad_o};
  localparam logic [12:0] BUS_REST = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
  localparam logic [71:0] ADDR_SEQ = 72'h21_22_23_24_25_26_41_42_43;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] rtc_val [0:8];
  logic [7:0] lat_addr = 8'h00;
  logic       prev_wr = 1'b1;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         viol = 0;
  int         wr_seen = 0;
  logic [7:0] addr_q [$];

  function automatic int addr_idx(input logic [7:0] a);
    case (a)
      8'h21: return 0; 8'h22: return 1; 8'h23: return 2;
      8'h24: return 3; 8'h25: return 4; 8'h26: return 5;
      8'h41: return 6; 8'h42: return 7; 8'h43: return 8;
      default: return -1;
    endcase
  endfunction

  // RTC model: latches the address while the block drives the bus, returns that register's byte
  always @(negedge clk) begin : rtc_model
    int i;
    if (ad_oe_o) lat_addr = ad_o;
    i = addr_idx(lat_addr);
    ad_i = (i >= 0) ? rtc_val[i] : 8'hEE;
  end

  // Per-cycle bus monitor and event counters
  always @(negedge clk) begin
    if (done_o) done_cnt++;
`ifdef RTC_BCD_CHECK_EN
    if (err_o) err_cnt++;
`endif
    if (!reset_i && ad_oe_o && !rd_n_o) viol++;
    if (!reset_i && !wr_n_o && a_d_o) viol++;
    if (!wr_n_o) wr_seen++;
    if (!wr_n_o && prev_wr) addr_q.push_back(ad_o);
    prev_wr = wr_n_o;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [71:0] exp_outs();
    return {rtc_val[0], rtc_val[1], rtc_val[2], rtc_val[3], rtc_val[4],
            rtc_val[5], rtc_val[6], rtc_val[7], rtc_val[8]};
  endfunction

  task automatic test_reset();
    reset_i = 1'b1; refresh_i = 1'b0;
    repeat (3) tick();
    n_cmp++; if (w_outs !== 72'h0) begin n_fail++; $display("FAIL reset_outs: got %h expected 0", w_outs); end
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_cmp++; if (w_bus !== BUS_REST) begin n_fail++; $display("FAIL reset_bus: got %h expected %h", w_bus, BUS_REST); end
  endtask

  task automatic test_auto_scan();
    int c, b, q0;
    logic found;
    logic [71:0] mid, got_addr;
    rtc_val = '{8'h59, 8'h30, 8'h12, 8'h25, 8'h07, 8'h16, 8'h05, 8'h04, 8'h03};
    q0 = addr_q.size();
    reset_i = 1'b0;
    c = 0; found = 1'b0;
    while (c < 400 && !found) begin
      tick(); c++;
      if (busy_o) found = 1'b1;
    end
    n_cmp++; if (c !== R) begin n_fail++; $display("FAIL auto_start_cycle: got %0d expected %0d", c, R); end
    b = 1; mid = 72'h0;
    while (b < 200 && !done_o) begin
      if (b == 90) mid = w_outs;
      tick(); b++;
    end
    n_cmp++; if (b !== 45 * P + 1) begin n_fail++; $display("FAIL auto_latency: got %0d expected %0d", b, 45 * P + 1); end
    n_cmp++; if (mid !== 72'h0) begin n_fail++; $display("FAIL auto_no_partial: got %h expected 0", mid); end
    n_cmp++; if (w_outs !== exp_outs()) begin n_fail++; $display("FAIL auto_outs: got %h expected %h", w_outs, exp_outs()); end
    n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL auto_valid: got %b expected 1", valid_o); end
    got_addr = 72'h0;
    for (int k = 0; k < 9; k++) got_addr = {got_addr[63:0], (q0 + k < addr_q.size()) ? addr_q[q0 + k] : 8'h00};
    n_cmp++; if (got_addr !== ADDR_SEQ) begin n_fail++; $display("FAIL auto_addr_seq: got %h expected %h", got_addr, ADDR_SEQ); end
    tick();
    n_cmp++; if ({done_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL auto_after_commit: got done/busy %b expected 00", {done_o, busy_o}); end
    n_cmp++; if (w_bus !== BUS_REST) begin n_fail++; $display("FAIL auto_idle_bus: got %h expected %h", w_bus, BUS_REST); end
  endtask

  task automatic test_back_to_back();
    int bc, d0;
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    d0 = done_cnt; bc = 0;
    refresh_i = 1'b1; tick(); refresh_i = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (busy_o) bc++;
      refresh_i = (i == 10);
      tick();
    end
    refresh_i = 1'b0;
    n_cmp++; if (bc !== 45 * P + 1) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d expected %0d", bc, 45 * P + 1); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 1", done_cnt - d0); end
    n_cmp++; if (w_outs !== exp_outs()) begin n_fail++; $display("FAIL b2b_outs: got %h expected %h", w_outs, exp_outs()); end
  endtask

  task automatic test_reset_mid_scan();
    int n, d0;
    refresh_i = 1'b1; tick(); refresh_i = 1'b0;
    n = 0;
    while (n < 200 && !(ad_oe_o && ad_o == 8'h25)) begin tick(); n++; end
    while (n < 200 && rd_n_o) begin tick(); n++; end
    n_cmp++; if (n >= 200) begin n_fail++; $display("FAIL mid_find_drd4: got timeout expected D_RD of index 4"); end
    d0 = done_cnt;
    reset_i = 1'b1; tick();
    n_cmp++; if (w_outs !== 72'h0) begin n_fail++; $display("FAIL mid_outs: got %h expected 0", w_outs); end
    n_cmp++; if ({valid_o, busy_o, done_o} !== 3'b000) begin n_fail++; $display("FAIL mid_flags: got %b expected 000", {valid_o, busy_o, done_o}); end
    n_cmp++; if (w_bus !== BUS_REST) begin n_fail++; $display("FAIL mid_bus: got %h expected %h", w_bus, BUS_REST); end
    reset_i = 1'b0;
    repeat (150) tick();
    n_cmp++; if (done_cnt !== d0) begin n_fail++; $display("FAIL mid_no_done: got %0d expected %0d", done_cnt - d0, 0); end
  endtask

  task automatic test_new_values();
    int n, d0;
    rtc_val = '{8'h00, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99, 8'h59, 8'h58, 8'h23};
    d0 = done_cnt;
    refresh_i = 1'b1; tick(); refresh_i = 1'b0;
    n = 0;
    while (n < 200 && !done_o) begin tick(); n++; end
    n_cmp++; if (w_outs !== exp_outs()) begin n_fail++; $display("FAIL new_outs: got %h expected %h", w_outs, exp_outs()); end
    n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL new_valid: got %b expected 1", valid_o); end
    repeat (5) tick();
    n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL new_dropped_tc: got %0d done pulses expected 1", done_cnt - d0); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL new_idle: got %b expected 0", busy_o); end
  endtask

  task automatic test_bus_rules();
    n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL bus_rules: got %0d violations expected 0", viol); end
    n_cmp++; if (wr_seen < 3 * 9 * P) begin n_fail++; $display("FAIL bus_wr_seen: got %0d expected >= %0d", wr_seen, 3 * 9 * P); end
  endtask

`ifdef RTC_BCD_CHECK_EN
  task automatic test_bcd_check();
    int n, d0, e0;
    logic [71:0] prev;
    prev = w_outs;
    rtc_val[1] = 8'h5A;
    d0 = done_cnt; e0 = err_cnt;
    refresh_i = 1'b1; tick(); refresh_i = 1'b0;
    n = 0;
    while (n < 200 && busy_o) begin tick(); n++; end
    repeat (3) tick();
    n_cmp++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL bcd_err_count: got %0d expected 1", err_cnt - e0); end
    n_cmp++; if (done_cnt !== d0) begin n_fail++; $display("FAIL bcd_no_done: got %0d expected 0", done_cnt - d0); end
    n_cmp++; if (w_outs !== prev) begin n_fail++; $display("FAIL bcd_outs_kept: got %h expected %h", w_outs, prev); end
    n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL bcd_valid_kept: got %b expected 1", valid_o); end
    rtc_val[1] = 8'h59;
  endtask
`endif

  initial begin
    rtc_val = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    @(negedge clk);
    test_reset();
    test_auto_scan();
    test_back_to_back();
    test_reset_mid_scan();
    test_new_values();
    test_bus_rules();
`ifdef RTC_BCD_CHECK_EN
    test_bcd_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
